ocm_mailbox_poller: RTL



---
 rtl/ocm_mailbox_poller_pkg.sv | 39 +++
 rtl/ocm_mailbox_poller_if.sv | 34 +++
 rtl/ocm_mailbox_poller_timer.sv | 28 ++
 rtl/ocm_mailbox_poller.sv | 139 +++++++++++++
 4 files changed

// File: rtl/ocm_mailbox_poller_pkg.sv
// Shared types and word-layout constants for the OCM mailbox poller.
package ocm_mailbox_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StCap,
        StWr
    } poller_state_e;

    // Command word written by the HPS.
    localparam int unsigned CMD_VALID_BIT = 31;
    localparam int unsigned CMD_SEQ_LSB   = 16;
    localparam int unsigned CMD_LED_LSB   = 0;

    // Status word written back by the fabric.
    localparam int unsigned STAT_ALIVE_BIT = 31;
    localparam int unsigned STAT_SEQ_LSB   = 16;
    localparam int unsigned STAT_POLL_LSB  = 8;
    localparam int unsigned STAT_KEY_LSB   = 4;
    localparam int unsigned STAT_SW_LSB    = 0;

    // Assemble the status word; unlisted bits stay zero.
    function automatic logic [31:0] pack_status(input logic [7:0] seq,
                                                input logic [7:0] poll,
                                                input logic [1:0] key,
                                                input logic [3:0] sw);
        logic [31:0] w;
        w = '0;
        w[STAT_ALIVE_BIT]         = 1'b1;
        w[STAT_SEQ_LSB +: 8]      = seq;
        w[STAT_POLL_LSB +: 8]     = poll;
        w[STAT_KEY_LSB +: 2]      = key;
        w[STAT_SW_LSB +: 4]       = sw;
        return w;
    endfunction

endpackage

// File: rtl/ocm_mailbox_poller_if.sv
// Avalon-style s2 port of the on-chip memory, as seen from the fabric.
interface ocm_mailbox_poller_if #(
    parameter int unsigned ADDR_W = 13
) ();

    logic [ADDR_W-1:0] s2_address;
    logic              s2_chipselect;
    logic              s2_write;
    logic [31:0]       s2_writedata;
    logic [3:0]        s2_byteenable;
    logic              s2_clken;
    logic [31:0]       s2_readdata;

    modport master (
        output s2_address,
        output s2_chipselect,
        output s2_write,
        output s2_writedata,
        output s2_byteenable,
        output s2_clken,
        input  s2_readdata
    );

    modport slave (
        input  s2_address,
        input  s2_chipselect,
        input  s2_write,
        input  s2_writedata,
        input  s2_byteenable,
        input  s2_clken,
        output s2_readdata
    );

endinterface

// File: rtl/ocm_mailbox_poller_timer.sv
// Free-running divider producing a one-cycle tick every POLL_DIV clocks.
module ocm_poll_timer #(
    parameter int unsigned POLL_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(POLL_DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    // Count 0..POLL_DIV-1 and wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ocm_mailbox_poller.sv
// Polls an HPS-written command word in on-chip memory, latches the LED
// value on a new sequence number and writes back an ack/status word.
module ocm_mailbox_poller
    import ocm_mailbox_pkg::*;
#(
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned CMD_ADDR     = 0,
    parameter int unsigned STAT_ADDR    = 1,
    parameter int unsigned POLL_DIV     = 50000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ocm_mailbox_poller_if.master s2,
    input  logic [1:0]           key_in,
    input  logic [3:0]           dipsw_in,
    output logic [7:0]           led_out,
    output logic                 cmd_strobe,
    output logic                 busy
);

    localparam logic [1:0] WAIT_INIT = (READ_LATENCY >= 2) ? 2'(READ_LATENCY - 2) : 2'd0;

    poller_state_e     state;
    logic              tick;
    logic [ADDR_W-1:0] addr_q;
    logic              cs_q;
    logic              wr_q;
    logic [7:0]        led_q;
    logic              strobe_q;
    logic [7:0]        last_seq;
    logic              has_seq;
    logic [7:0]        poll_cnt8;
    logic [1:0]        wait_cnt;

    logic              cmd_valid;
    logic [7:0]        cmd_seq;
    logic [7:0]        cmd_led;
    logic              accept;
    logic              unused_cmd_bits;

    ocm_poll_timer #(
        .POLL_DIV (POLL_DIV)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign cmd_valid       = s2.s2_readdata[CMD_VALID_BIT];
    assign cmd_seq         = s2.s2_readdata[CMD_SEQ_LSB +: 8];
    assign cmd_led         = s2.s2_readdata[CMD_LED_LSB +: 8];
    assign unused_cmd_bits = ^{s2.s2_readdata[30:24], s2.s2_readdata[15:8]};
    assign accept          = cmd_valid && (!has_seq || (cmd_seq != last_seq));

    assign s2.s2_address    = addr_q;
    assign s2.s2_chipselect = cs_q;
    assign s2.s2_write      = wr_q;
    assign s2.s2_byteenable = 4'hF;
    assign s2.s2_clken      = 1'b1;
    // Combinational so key/dipsw are taken in the WR cycle itself.
    assign s2.s2_writedata  = (state == StWr) ?
                              pack_status(last_seq, poll_cnt8, key_in, dipsw_in) : 32'h0;

    assign led_out    = led_q;
    assign cmd_strobe = strobe_q;
    assign busy       = (state != StIdle);

    // Poll transaction FSM: read command, capture, write status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            addr_q    <= '0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            led_q     <= 8'h00;
            strobe_q  <= 1'b0;
            last_seq  <= 8'h00;
            has_seq   <= 1'b0;
            poll_cnt8 <= 8'h00;
            wait_cnt  <= 2'd0;
        end else begin
            strobe_q <= 1'b0;
            case (state)
                StIdle: begin
                    // Ticks in any other state are simply dropped.
                    if (tick) begin
                        state  <= StRd;
                        cs_q   <= 1'b1;
                        wr_q   <= 1'b0;
                        addr_q <= ADDR_W'(CMD_ADDR);
                    end
                end
                StRd: begin
                    cs_q   <= 1'b0;
                    addr_q <= '0;
                    if (READ_LATENCY > 1) begin
                        state    <= StWait;
                        wait_cnt <= WAIT_INIT;
                    end else begin
                        state <= StCap;
                    end
                end
                StWait: begin
                    if (wait_cnt == 2'd0) begin
                        state <= StCap;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                StCap: begin
                    if (accept) begin
                        led_q    <= cmd_led;
                        last_seq <= cmd_seq;
                        has_seq  <= 1'b1;
                        strobe_q <= 1'b1;
                    end
                    state  <= StWr;
                    cs_q   <= 1'b1;
                    wr_q   <= 1'b1;
                    addr_q <= ADDR_W'(STAT_ADDR);
                end
                StWr: begin
                    state     <= StIdle;
                    cs_q      <= 1'b0;
                    wr_q      <= 1'b0;
                    addr_q    <= '0;
                    poll_cnt8 <= poll_cnt8 + 8'd1;
                end
                default: begin
                    state <= StIdle;
                    cs_q  <= 1'b0;
                    wr_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
